sid_i2s_tx: RTL and testbench

Serializing I2S transmitter that consumes the stereo `sid::audio_t` sample word produced by the SID API block and drives an external audio DAC. Sample handoff is a one-cycle strobe into a single-entry holding register. Frames are generated autonomously from `clk` by a bit-clock divider. The block sits between the SID API audio output and the FPGA DAC pins, in the same clock domain as the SID pipelines.

---
 rtl/sid_i2s_tx.sv | 86 ++++++++
 tb/tb_sid_i2s_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sid_i2s_tx.sv
// I2S transmitter: serializes stereo 24-bit samples (sid::audio_t layout) into 64-slot frames.
// Define SID_I2S_LEFT_JUSTIFIED_EN to emit left-justified frames instead of standard I2S.
module sid_i2s_tx #(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [47:0] audio_i,
  input  logic        audio_stb,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_sd,
  output logic        ovf,
  output logic        unf
);

  localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [63:0]      frame;
  logic [47:0]      pend;
  logic             pend_v;
  logic [47:0]      last;

  logic             div_tc;
  logic             fall_evt;
  logic             frame_load;
  logic [47:0]      src;
  logic [63:0]      frame_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    div_tc     = (div_cnt == DIV_W'(BCK_DIV - 1));
    fall_evt   = div_tc & i2s_bck;
    frame_load = fall_evt & (bit_cnt == 6'd63);
    src        = last;
    if (audio_stb)   src = audio_i;
    else if (pend_v) src = pend;
`ifdef SID_I2S_LEFT_JUSTIFIED_EN
    frame_next = {src[47:24], 8'h00, src[23:0], 8'h00};
`else
    frame_next = {1'b0, src[47:24], 8'h00, src[23:0], 7'h00};
`endif
  end

  // NOTE: the sample registers are cleared on reset too, so a frame after reset is true silence.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      div_cnt <= '0;
      i2s_bck <= 1'b0;
      bit_cnt <= '0;
      frame   <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      last    <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      ovf     <= 1'b0;
      unf     <= 1'b0;
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc) i2s_bck <= ~i2s_bck;

      if (fall_evt) begin
        bit_cnt <= bit_cnt + 6'd1;
        frame   <= frame_load ? frame_next : {frame[62:0], 1'b0};
      end

      // A strobe on the load cycle bypasses the holding register and never counts as overflow.
      if (frame_load) begin
        last   <= src;
        pend_v <= 1'b0;
        unf    <= ~audio_stb & ~pend_v;
      end else if (audio_stb) begin
        pend   <= audio_i;
        pend_v <= 1'b1;
        ovf    <= pend_v;
      end
    end
  end

  assign i2s_lrck = bit_cnt[5];
  assign i2s_sd   = frame[63];

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Self-checking bench for sid_i2s_tx: table of single-frame scenarios plus reset/free-run sequences.
module tb_sid_i2s_tx;

  localparam int TB_DIV = 2;
  localparam logic [47:0] IDLE_DATA = 48'hDEAD_BEEF_CAFE;

  logic        clk = 1'b0;
  logic        res_n;
  logic [47:0] audio_i;
  logic        audio_stb;
  logic        i2s_bck, i2s_lrck, i2s_sd, ovf, unf;

  int checks = 0;
  int errors = 0;
  int cyc;

  sid_i2s_tx #(.BCK_DIV(TB_DIV)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .audio_i   (audio_i),
    .audio_stb (audio_stb),
    .i2s_bck   (i2s_bck),
    .i2s_lrck  (i2s_lrck),
    .i2s_sd    (i2s_sd),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  // Cycles since reset release, counted by the bench itself.
  always @(posedge clk) begin
    if (!res_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    bit          has_s0;
    logic [47:0] s0;
    int          off0;
    bit          has_s1;
    logic [47:0] s1;
    int          off1;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    int          exp_ovf;
    bit          exp_unf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bck(input int c);
    return ((c / TB_DIV) % 2) == 1;
  endfunction

  function automatic logic exp_lrck(input int c);
    return ((c / (2 * TB_DIV)) % 64) >= 32;
  endfunction

  // Reference slot map: position p is the p-th bit on i2s_sd after a frame load.
  function automatic logic [63:0] expect_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] f;
    f = '0;
    for (int p = 0; p < 64; p++) begin
`ifdef SID_I2S_LEFT_JUSTIFIED_EN
      if (p <= 23)                f[63-p] = l[23-p];
      else if (p >= 32 && p <= 55) f[63-p] = r[55-p];
`else
      if (p >= 1 && p <= 24)       f[63-p] = l[24-p];
      else if (p >= 33 && p <= 56) f[63-p] = r[56-p];
`endif
    end
    return f;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bck"},  i2s_bck,  1'b0);
    check({tag, "_lrck"}, i2s_lrck, 1'b0);
    check({tag, "_sd"},   i2s_sd,   1'b0);
    check({tag, "_ovf"},  ovf,      1'b0);
    check({tag, "_unf"},  unf,      1'b0);
  endtask

  // Observe cycles 1..last_c after release with no strobes; unf expected only at unf_at.
  task automatic free_run(input string tag, input int last_c, input int exp_unf_n);
    int bad_bck, bad_lr, bad_sd, bad_ovf, bad_unf, unf_n;
    bad_bck = 0; bad_lr = 0; bad_sd = 0; bad_ovf = 0; bad_unf = 0; unf_n = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (i2s_bck !== exp_bck(cyc))   bad_bck++;
      if (i2s_lrck !== exp_lrck(cyc)) bad_lr++;
      if (i2s_sd !== 1'b0)            bad_sd++;
      if (ovf !== 1'b0)               bad_ovf++;
      if (unf === 1'b1) unf_n++;
      if (unf !== ((cyc % 256 == 0) ? 1'b1 : 1'b0)) bad_unf++;
    end
    check({tag, "_bck_wave_errs"},  bad_bck, 0);
    check({tag, "_lrck_wave_errs"}, bad_lr,  0);
    check({tag, "_sd_silence_errs"}, bad_sd, 0);
    check({tag, "_ovf_spurious"},   bad_ovf, 0);
    check({tag, "_unf_count"},      unf_n,   exp_unf_n);
    check({tag, "_unf_timing_errs"}, bad_unf, 0);
  endtask

  // Frame load at posedge L; strobes drive into posedge L+off; capture the frame that follows.
  task automatic run_vec(input int i);
    int          L, ovf_n, lr_bad, p;
    logic        unf_at;
    logic [63:0] cap;
    L = 256 * (4 + 2 * i);
    ovf_n = 0; lr_bad = 0; unf_at = 1'bx; cap = '0;
    while (cyc < L - 256) @(negedge clk);
    for (int c = L - 256; c <= L + 254; c++) begin
      if (cyc >= L - 255 && ovf === 1'b1) ovf_n++;
      if (cyc == L) unf_at = unf;
      if (cyc >= L && ((cyc - L) % 4) == 1) begin
        p = (cyc - L) / 4;
        cap[63-p] = i2s_sd;
        if (i2s_lrck !== (p >= 32)) lr_bad++;
      end
      if (vecs[i].has_s0 && cyc + 1 == L + vecs[i].off0) begin
        audio_stb = 1'b1; audio_i = vecs[i].s0;
      end else if (vecs[i].has_s1 && cyc + 1 == L + vecs[i].off1) begin
        audio_stb = 1'b1; audio_i = vecs[i].s1;
      end else begin
        audio_stb = 1'b0; audio_i = IDLE_DATA;
      end
      @(negedge clk);
    end
    audio_stb = 1'b0;
    check({vecs[i].name, "_frame"}, cap, expect_frame(vecs[i].exp_l, vecs[i].exp_r));
    check({vecs[i].name, "_lrck_errs"}, lr_bad, 0);
    check({vecs[i].name, "_ovf_count"}, ovf_n, vecs[i].exp_ovf);
    check({vecs[i].name, "_unf_at_load"}, unf_at, vecs[i].exp_unf);
  endtask

  task automatic strobe_at(input int post, input logic [47:0] d);
    while (cyc < post - 1) @(negedge clk);
    audio_stb = 1'b1; audio_i = d;
    @(negedge clk);
    audio_stb = 1'b0; audio_i = IDLE_DATA;
  endtask

  initial begin
    int L;
    vecs[0] = '{"mid_frame",    1, 48'hA5A5A5_3C3C3C, -100, 0, 48'h0, 0,
                24'hA5A5A5, 24'h3C3C3C, 0, 0};
    vecs[1] = '{"overwrite",    1, 48'h000001_7FFFFF, -120, 1, 48'h800000_FFFFFF, -40,
                24'h800000, 24'hFFFFFF, 1, 0};
    vecs[2] = '{"coincident",   1, 48'h123456_654321, 0, 0, 48'h0, 0,
                24'h123456, 24'h654321, 0, 0};
    vecs[3] = '{"repeat_last",  0, 48'h0, 0, 0, 48'h0, 0,
                24'h123456, 24'h654321, 0, 1};
    vecs[4] = '{"back_to_back", 1, 48'h111111_222222, -10, 1, 48'hFEDCBA_012345, -9,
                24'hFEDCBA, 24'h012345, 1, 0};
    vecs[5] = '{"pend_bypass",  1, 48'h0F0F0F_F0F0F0, -60, 1, 48'h55AA55_AA55AA, 0,
                24'h55AA55, 24'hAA55AA, 0, 0};
    vecs[6] = '{"justify",      1, 48'hC00001_400003, -30, 0, 48'h0, 0,
                24'hC00001, 24'h400003, 0, 0};

    res_n = 1'b0; audio_stb = 1'b0; audio_i = IDLE_DATA;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    res_n = 1'b1;

    // First frame is silence; unf from the wrap-loads at 256 and 512.
    free_run("startup", 520, 2);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset at bit 40 of a frame carrying right=FFFFFF, with another sample pending.
    L = 256 * 18;
    strobe_at(L - 50, 48'h000000_FFFFFF);
    strobe_at(L + 10, 48'h7ABCDE_13579B);
    while (cyc < L + 160) @(negedge clk);
    check("pre_reset_lrck", i2s_lrck, 1'b1);
    check("pre_reset_sd",   i2s_sd,   1'b1);
    res_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(negedge clk);
    res_n = 1'b1;
    free_run("post_reset", 511, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
